// File: rtl/merge_2_streams_pkg.sv
// Shared types and the tie-to-A ordering function for the two-stream merger.
package merge_2_streams_pkg;

    // Compare operands are zero-extended to this width before ordering.
    localparam int MAX_WIDTH = 64;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MERGE   = 3'd1,
        DRAIN_A = 3'd2,
        DRAIN_B = 3'd3,
        FLUSH   = 3'd4
    } state_t;

    // Equal keys pick A so elements of A stay ahead of equal elements of B.
    function automatic logic sel_a(
        input logic [MAX_WIDTH-1:0] a,
        input logic [MAX_WIDTH-1:0] b,
        input logic                 descend
    );
        return descend ? (a >= b) : (a <= b);
    endfunction

endpackage

// File: rtl/merge_2_streams_if.sv
// Handshake bundle for the merger: run control, two input streams, one output stream.
interface merge_2_streams_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             start;
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_last;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_last;
    logic             b_ready;
    logic [WIDTH-1:0] data_out;
    logic             push;
    logic             out_ready;
    logic             out_last;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] out_count;

    modport master (
        output start, a_data, a_valid, a_last, b_data, b_valid, b_last, out_ready,
        input  a_ready, b_ready, data_out, push, out_last, busy, done, out_count
    );

    modport slave (
        input  start, a_data, a_valid, a_last, b_data, b_valid, b_last, out_ready,
        output a_ready, b_ready, data_out, push, out_last, busy, done, out_count
    );

endinterface

// File: rtl/merge_2_streams_cmp_select.sv
// Combinational head-of-stream comparator: decides which stream wins and muxes its element.
module cmp_select
    import merge_2_streams_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DESCEND = 0
) (
    input  logic [WIDTH-1:0] a_data,
    input  logic [WIDTH-1:0] b_data,
    output logic             sel_a,
    output logic [WIDTH-1:0] sel_data
);

    localparam logic DESC_BIT = (DESCEND != 0);

    assign sel_a = merge_2_streams_pkg::sel_a(MAX_WIDTH'(a_data), MAX_WIDTH'(b_data), DESC_BIT);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_mux
            assign sel_data[gi] = sel_a ? a_data[gi] : b_data[gi];
        end
    endgenerate

endmodule

// File: rtl/merge_2_streams.sv
// Merges two pre-sorted valid/ready streams into one sorted stream through a 1-entry output register.
module merge_2_streams
    import merge_2_streams_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DESCEND = 0,
    parameter int CNT_W   = 16
) (
    input  logic              clock,
    input  logic              reset,
    merge_2_streams_if.slave  bus
);

    state_t           state_reg;
    logic [WIDTH-1:0] data_reg;
    logic             push_reg;
    logic             last_reg;
    logic             done_reg;
    logic [CNT_W-1:0] count_reg;

    logic             sel_a;
    logic [WIDTH-1:0] sel_data;
    logic             slot_free;
    logic             accept;
    logic             a_take;
    logic             b_take;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic             load_last;

    cmp_select #(
        .WIDTH   (WIDTH),
        .DESCEND (DESCEND)
    ) u_cmp (
        .a_data   (bus.a_data),
        .b_data   (bus.b_data),
        .sel_a    (sel_a),
        .sel_data (sel_data)
    );

    assign slot_free = !push_reg || bus.out_ready;
    assign accept    = push_reg && bus.out_ready;
    assign load      = a_take || b_take;

    // A comparison is only meaningful with both heads present, so MERGE waits for both valids.
    always_comb begin
        a_take    = 1'b0;
        b_take    = 1'b0;
        load_data = sel_data;
        load_last = 1'b0;
        case (state_reg)
            MERGE: begin
                if (bus.a_valid && bus.b_valid && slot_free) begin
                    a_take = sel_a;
                    b_take = !sel_a;
                end
            end
            DRAIN_A: begin
                a_take    = bus.a_valid && slot_free;
                load_data = bus.a_data;
                load_last = bus.a_last;
            end
            DRAIN_B: begin
                b_take    = bus.b_valid && slot_free;
                load_data = bus.b_data;
                load_last = bus.b_last;
            end
            default: begin
                a_take = 1'b0;
                b_take = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            data_reg  <= '0;
            push_reg  <= 1'b0;
            last_reg  <= 1'b0;
            done_reg  <= 1'b0;
            count_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            if (accept) begin
                count_reg <= count_reg + 1'b1;
                push_reg  <= 1'b0;
                last_reg  <= 1'b0;
            end
            // A load in the same cycle as an accept keeps push high for back-to-back beats.
            if (load) begin
                data_reg <= load_data;
                push_reg <= 1'b1;
                last_reg <= load_last;
            end
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        state_reg <= MERGE;
                        count_reg <= '0;
                    end
                end
                MERGE: begin
                    if (a_take && bus.a_last) begin
                        state_reg <= DRAIN_B;
                    end else if (b_take && bus.b_last) begin
                        state_reg <= DRAIN_A;
                    end
                end
                DRAIN_A: begin
                    if (a_take && bus.a_last) begin
                        state_reg <= FLUSH;
                    end
                end
                DRAIN_B: begin
                    if (b_take && bus.b_last) begin
                        state_reg <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (accept && last_reg) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.a_ready   = a_take;
    assign bus.b_ready   = b_take;
    assign bus.data_out  = data_reg;
    assign bus.push      = push_reg;
    assign bus.out_last  = last_reg;
    assign bus.busy      = (state_reg != IDLE);
    assign bus.done      = done_reg;
    assign bus.out_count = count_reg;

endmodule

// File: tb/tb_merge_2_streams.sv
// Directed bench for merge_2_streams: ascending and descending instances, table of merge runs plus a mid-run reset.
module tb_merge_2_streams;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       use_desc;
    logic       start;
    logic [7:0] a_data, b_data;
    logic       a_valid, a_last, b_valid, b_last, out_ready;
    logic       a_ready, b_ready, push, out_last, busy, done;
    logic [7:0] data_out;
    logic [15:0] out_count;

    merge_2_streams_if #(.WIDTH(8), .CNT_W(16)) if_asc ();
    merge_2_streams_if #(.WIDTH(8), .CNT_W(16)) if_dsc ();

    merge_2_streams #(.WIDTH(8), .DESCEND(0), .CNT_W(16)) dut_asc (
        .clock (clk),
        .reset (reset),
        .bus   (if_asc)
    );

    merge_2_streams #(.WIDTH(8), .DESCEND(1), .CNT_W(16)) dut_dsc (
        .clock (clk),
        .reset (reset),
        .bus   (if_dsc)
    );

    // Only the selected instance sees start and valids; data and out_ready are shared.
    assign if_asc.start     = start & ~use_desc;
    assign if_dsc.start     = start & use_desc;
    assign if_asc.a_valid   = a_valid & ~use_desc;
    assign if_dsc.a_valid   = a_valid & use_desc;
    assign if_asc.b_valid   = b_valid & ~use_desc;
    assign if_dsc.b_valid   = b_valid & use_desc;
    assign if_asc.a_data    = a_data;
    assign if_dsc.a_data    = a_data;
    assign if_asc.b_data    = b_data;
    assign if_dsc.b_data    = b_data;
    assign if_asc.a_last    = a_last;
    assign if_dsc.a_last    = a_last;
    assign if_asc.b_last    = b_last;
    assign if_dsc.b_last    = b_last;
    assign if_asc.out_ready = out_ready;
    assign if_dsc.out_ready = out_ready;

    assign a_ready   = use_desc ? if_dsc.a_ready   : if_asc.a_ready;
    assign b_ready   = use_desc ? if_dsc.b_ready   : if_asc.b_ready;
    assign push      = use_desc ? if_dsc.push      : if_asc.push;
    assign out_last  = use_desc ? if_dsc.out_last  : if_asc.out_last;
    assign busy      = use_desc ? if_dsc.busy      : if_asc.busy;
    assign done      = use_desc ? if_dsc.done      : if_asc.done;
    assign data_out  = use_desc ? if_dsc.data_out  : if_asc.data_out;
    assign out_count = use_desc ? if_dsc.out_count : if_asc.out_count;

    typedef struct packed {
        logic             desc;
        logic             toggle;
        logic             b_gaps;
        int               start_again;
        int               alen;
        int               blen;
        int               olen;
        logic [3:0][7:0]  a;
        logic [3:0][7:0]  b;
        logic [7:0][7:0]  exp_data;
        logic [7:0]       exp_src;
        int               done_cyc;
    } vec_t;

    vec_t vecs [5];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        start     = 1'b0;
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        a_last    = 1'b0;
        b_last    = 1'b0;
        a_data    = 8'd0;
        b_data    = 8'd0;
        out_ready = 1'b1;
    endtask

    task automatic run_vec(input int v);
        vec_t t;
        int   ai, bi, oi, ci, cyc, done_due;
        logic finished, prev_stall, prev_last;
        logic [7:0] prev_data;
        t          = vecs[v];
        use_desc   = t.desc;
        ai = 0; bi = 0; oi = 0; ci = 0; done_due = -1;
        finished   = 1'b0;
        prev_stall = 1'b0;
        prev_last  = 1'b0;
        prev_data  = 8'd0;
        cyc        = 0;
        while (!finished && cyc < 200) begin
            @(negedge clk);
            start     = (cyc == 0) || (t.start_again != 0 && cyc == t.start_again);
            a_valid   = (cyc > 0) && (ai < t.alen);
            a_data    = (ai < t.alen) ? t.a[ai[1:0]] : 8'd0;
            a_last    = (ai == t.alen - 1);
            b_valid   = (cyc > 0) && (bi < t.blen) && !(t.b_gaps && (cyc % 3 == 1));
            b_data    = (bi < t.blen) ? t.b[bi[1:0]] : 8'd0;
            b_last    = (bi == t.blen - 1);
            out_ready = t.toggle ? (cyc % 2 == 1) : 1'b1;
            #1;
            chk("ready_exclusive", 32'(a_ready & b_ready), 32'd0);
            chk("done_pulse", 32'(done), 32'(cyc == done_due));
            if (prev_stall) begin
                chk("stall_push", 32'(push), 32'd1);
                chk("stall_data", 32'(data_out), 32'(prev_data));
                chk("stall_last", 32'(out_last), 32'(prev_last));
            end
            if (push && !out_ready)
                chk("stall_no_consume", 32'(a_ready | b_ready), 32'd0);
            if (push && out_ready) begin
                if (oi >= t.olen) begin
                    chk("extra_beat", 32'(oi), 32'(t.olen - 1));
                end else begin
                    chk("beat_data", 32'(data_out), 32'(t.exp_data[oi[2:0]]));
                    chk("beat_last", 32'(out_last), 32'(oi == t.olen - 1));
                    if (oi == t.olen - 1) done_due = cyc + 1;
                end
                oi++;
            end
            if (a_valid && a_ready) begin
                if (ci < 8) chk("consume_src_a", 32'd0, 32'(t.exp_src[ci[2:0]]));
                ci++;
                ai++;
            end
            if (b_valid && b_ready) begin
                if (ci < 8) chk("consume_src_b", 32'd1, 32'(t.exp_src[ci[2:0]]));
                ci++;
                bi++;
            end
            if (cyc == done_due) begin
                chk("run_done_busy", 32'(busy), 32'd0);
                chk("run_out_count", 32'(out_count), 32'(t.olen));
                chk("run_beats", 32'(oi), 32'(t.olen));
                if (t.done_cyc != 0) chk("run_done_cycle", 32'(cyc), 32'(t.done_cyc));
                finished = 1'b1;
            end
            prev_stall = push && !out_ready;
            prev_data  = data_out;
            prev_last  = out_last;
            cyc++;
        end
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL run_timeout: vector %0d got %0d beats required %0d", v, oi, t.olen);
        end
        $display("run %0d: desc=%0d beats=%0d cycles=%0d", v, t.desc, oi, cyc);
        idle_inputs();
    endtask

    initial begin
        vecs[0] = '{desc:1'b0, toggle:1'b0, b_gaps:1'b0, start_again:0, alen:3, blen:2, olen:5,
                    a:{8'd0, 8'd9, 8'd7, 8'd3}, b:{8'd0, 8'd0, 8'd8, 8'd4},
                    exp_data:{24'd0, 8'd9, 8'd8, 8'd7, 8'd4, 8'd3}, exp_src:8'b0000_1010, done_cyc:7};
        vecs[1] = '{desc:1'b0, toggle:1'b0, b_gaps:1'b0, start_again:0, alen:2, blen:1, olen:3,
                    a:{8'd0, 8'd0, 8'd5, 8'd5}, b:{8'd0, 8'd0, 8'd0, 8'd5},
                    exp_data:{40'd0, 8'd5, 8'd5, 8'd5}, exp_src:8'b0000_0100, done_cyc:5};
        vecs[2] = '{desc:1'b1, toggle:1'b0, b_gaps:1'b0, start_again:0, alen:2, blen:1, olen:3,
                    a:{8'd0, 8'd0, 8'd10, 8'd200}, b:{8'd0, 8'd0, 8'd0, 8'd100},
                    exp_data:{40'd0, 8'd10, 8'd100, 8'd200}, exp_src:8'b0000_0010, done_cyc:5};
        vecs[3] = vecs[0];
        vecs[3].toggle   = 1'b1;
        vecs[3].done_cyc = 0;
        vecs[4] = '{desc:1'b0, toggle:1'b0, b_gaps:1'b1, start_again:4, alen:1, blen:3, olen:4,
                    a:{8'd0, 8'd0, 8'd0, 8'd1}, b:{8'd0, 8'd4, 8'd3, 8'd2},
                    exp_data:{32'd0, 8'd4, 8'd3, 8'd2, 8'd1}, exp_src:8'b0000_1110, done_cyc:8};

        use_desc = 1'b0;
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_push", 32'(push), 32'd0);
        chk("reset_last", 32'(out_last), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_data", 32'(data_out), 32'd0);
        chk("reset_count", 32'(out_count), 32'd0);
        chk("reset_ready", 32'(a_ready | b_ready), 32'd0);
        $display("reset: push=%0d busy=%0d count=%0d", push, busy, out_count);

        for (int v = 0; v < 5; v++) run_vec(v);

        // Reset in the middle of a merge with a beat pending in the output register.
        use_desc = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_valid = 1'b1; a_data = 8'd3; a_last = 1'b0;
        b_valid = 1'b1; b_data = 8'd4; b_last = 1'b0;
        @(negedge clk);
        a_data = 8'd7;
        #1;
        chk("midrun_push", 32'(push), 32'd1);
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        #1;
        chk("midrun_count", 32'(out_count), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("after_reset_push", 32'(push), 32'd0);
        chk("after_reset_busy", 32'(busy), 32'd0);
        chk("after_reset_count", 32'(out_count), 32'd0);
        chk("after_reset_data", 32'(data_out), 32'd0);
        $display("mid-run reset: push=%0d busy=%0d count=%0d", push, busy, out_count);

        run_vec(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
